multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32I core datapath. It fetches each instruction over a req/ack instruction-memory port, holds it in an internal instruction register, and steps an IF/ID/EX/MEM/WB state machine. In each state it emits one-cycle PC-write, register-write and data-memory strobes. It sits between the memories and the combinational decoder/ALU, which consume `ir` and report `branch_taken` back.

---
 rtl/multicycle_ctrl_if.sv | 20 ++
 rtl/multicycle_ctrl.sv | 152 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Instruction- and data-memory handshake bundle between the sequencer and the memories.
// The controller is the master; the memory side (or bench) is the slave.
interface multicycle_ctrl_if;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the RV32I datapath.
// Requests and strobes are combinational from state and ir, forced low while rstn is low.
module multicycle_ctrl #(
    parameter logic [31:0] RESET_IR = 32'h0000_0013
) (
    input  logic                    clk,
    input  logic                    rstn,
    multicycle_ctrl_if.master       bus,
    input  logic                    branch_taken,
    output logic [31:0]             ir,
    output logic                    pc_we,
    output logic [1:0]              pc_sel,
    output logic                    rf_we,
    output logic [1:0]              wb_sel,
    output logic [2:0]              state,
    output logic                    halt,
    output logic                    illegal,
    output logic [31:0]             retired
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_ir;
    logic [31:0] r_retired;
    logic        r_illegal;

    logic w_imem_req, w_dmem_req, w_dmem_we, w_pc_we, w_rf_we;
    logic [1:0] w_pc_sel, w_wb_sel;
    logic w_load_ir, w_inc, w_set_ill;

    logic [6:0] w_op;
    logic w_is_r, w_is_i, w_is_load, w_is_store, w_is_br, w_is_jal, w_is_jalr, w_is_sys;
    logic w_is_jump, w_is_legal;

    assign w_op       = r_ir[6:0];
    assign w_is_r     = (w_op == 7'b0110011);
    assign w_is_i     = (w_op == 7'b0010011);
    assign w_is_load  = (w_op == 7'b0000011);
    assign w_is_store = (w_op == 7'b0100011);
    assign w_is_br    = (w_op == 7'b1100011);
    assign w_is_jal   = (w_op == 7'b1101111);
    assign w_is_jalr  = (w_op == 7'b1100111);
    assign w_is_sys   = (w_op == 7'b1110011);
    assign w_is_jump  = w_is_jal | w_is_jalr;
    assign w_is_legal = w_is_r | w_is_i | w_is_load | w_is_store | w_is_br | w_is_jump | w_is_sys;

    always_comb begin
        w_next_state = r_state;
        w_imem_req   = 1'b0;
        w_dmem_req   = 1'b0;
        w_dmem_we    = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_sel     = 2'd0;
        w_rf_we      = 1'b0;
        w_wb_sel     = 2'd0;
        w_load_ir    = 1'b0;
        w_inc        = 1'b0;
        w_set_ill    = 1'b0;
        case (r_state)
            S_IF: begin
                w_imem_req = 1'b1;
                if (bus.imem_ack) begin
                    w_load_ir    = 1'b1;
                    w_next_state = S_ID;
                end
            end
            S_ID: begin
                if (!w_is_legal) begin
                    w_set_ill    = 1'b1;
                    w_next_state = S_HALT;
                end else if (w_is_sys) begin
                    w_next_state = S_HALT;
                end else begin
                    w_next_state = S_EX;
                end
            end
            S_EX: begin
                if (w_is_br) begin
                    w_pc_we      = 1'b1;
                    w_pc_sel     = branch_taken ? 2'd1 : 2'd0;
                    w_inc        = 1'b1;
                    w_next_state = S_IF;
                end else if (w_is_load || w_is_store) begin
                    w_next_state = S_MEM;
                end else begin
                    w_next_state = S_WB;
                end
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = w_is_store;
                if (bus.dmem_ack) begin
                    if (w_is_store) begin
                        // Stores retire here; they never visit WB.
                        w_pc_we      = 1'b1;
                        w_inc        = 1'b1;
                        w_next_state = S_IF;
                    end else begin
                        w_next_state = S_WB;
                    end
                end
            end
            S_WB: begin
                w_rf_we      = 1'b1;
                w_wb_sel     = w_is_load ? 2'd1 : (w_is_jump ? 2'd2 : 2'd0);
                w_pc_we      = 1'b1;
                w_pc_sel     = w_is_jump ? 2'd2 : 2'd0;
                w_inc        = 1'b1;
                w_next_state = S_IF;
            end
            S_HALT: w_next_state = S_HALT;
            default: w_next_state = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= S_IF;
            r_ir      <= RESET_IR;
            r_retired <= 32'd0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_load_ir) r_ir <= bus.imem_rdata;
            if (w_inc)     r_retired <= r_retired + 32'd1;
            if (w_set_ill) r_illegal <= 1'b1;
        end
    end

    assign bus.imem_req = rstn & w_imem_req;
    assign bus.dmem_req = rstn & w_dmem_req;
    assign bus.dmem_we  = rstn & w_dmem_we;
    assign pc_we        = rstn & w_pc_we;
    assign pc_sel       = rstn ? w_pc_sel : 2'd0;
    assign rf_we        = rstn & w_rf_we;
    assign wb_sel       = rstn ? w_wb_sel : 2'd0;
    assign ir           = r_ir;
    assign state        = r_state;
    assign halt         = (r_state == S_HALT);
    assign illegal      = r_illegal;
    assign retired      = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench: each instruction is expanded into its expected per-cycle trace
// (from class, wait counts and branch outcome), which one process drives and checks.
module tb_multicycle_ctrl;

    localparam logic [31:0] RESET_IR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn;
    logic        branch_taken;
    logic [31:0] ir, retired;
    logic        pc_we, rf_we, halt, illegal;
    logic [1:0]  pc_sel, wb_sel;
    logic [2:0]  state;

    multicycle_ctrl_if bus_if ();

    multicycle_ctrl #(.RESET_IR(RESET_IR)) dut (
        .clk(clk), .rstn(rstn), .bus(bus_if), .branch_taken(branch_taken),
        .ir(ir), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .state(state), .halt(halt), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ia;
        logic [31:0] rd;
        logic        da;
        logic        bt;
        logic [2:0]  st;
        logic        ireq, dreq, dwe, pcwe;
        logic [1:0]  pcsel;
        logic        rfwe;
        logic [1:0]  wbsel;
        logic        hlt, ill;
        logic [31:0] ret, ir;
    } cyc_t;

    cyc_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_ret;
    logic [31:0] m_ir;
    logic        m_ill;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_ret = 32'd0;
        m_ir  = RESET_IR;
        m_ill = 1'b0;
    endfunction

    // A cycle with no expected activity; acks are random since the matching request is low.
    function automatic cyc_t idle_cyc(input logic [2:0] st);
        cyc_t c;
        c = '0;
        c.ia  = 1'($urandom_range(0, 1));
        c.rd  = $urandom;
        c.da  = 1'($urandom_range(0, 1));
        c.bt  = 1'($urandom_range(0, 1));
        c.st  = st;
        c.hlt = (st == 3'd5);
        c.ill = m_ill;
        c.ret = m_ret;
        c.ir  = m_ir;
        return c;
    endfunction

    task automatic gen_instr(input logic [31:0] instr, input int wi, input int wd,
                             input logic bt, output int len);
        cyc_t c;
        int n0;
        logic [6:0] op;
        logic is_ld, is_st, is_br, is_jmp, is_sys, legal;
        n0 = q.size();
        op = instr[6:0];
        is_ld  = (op == 7'h03);
        is_st  = (op == 7'h23);
        is_br  = (op == 7'h63);
        is_jmp = (op == 7'h6F) || (op == 7'h67);
        is_sys = (op == 7'h73);
        legal  = is_ld || is_st || is_br || is_jmp || is_sys || (op == 7'h33) || (op == 7'h13);
        for (int i = 0; i < wi; i++) begin
            c = idle_cyc(3'd0); c.ia = 1'b0; c.ireq = 1'b1; q.push_back(c);
        end
        c = idle_cyc(3'd0); c.ia = 1'b1; c.rd = instr; c.ireq = 1'b1; q.push_back(c);
        m_ir = instr;
        c = idle_cyc(3'd1); q.push_back(c);
        if (!legal || is_sys) begin
            if (!legal) m_ill = 1'b1;
            len = q.size() - n0;
            return;
        end
        c = idle_cyc(3'd2);
        if (is_br) begin
            c.bt = bt; c.pcwe = 1'b1; c.pcsel = bt ? 2'd1 : 2'd0;
            q.push_back(c);
            m_ret++;
            len = q.size() - n0;
            return;
        end
        q.push_back(c);
        if (is_ld || is_st) begin
            for (int i = 0; i <= wd; i++) begin
                c = idle_cyc(3'd3);
                c.da = (i == wd); c.dreq = 1'b1; c.dwe = is_st;
                if (is_st && i == wd) c.pcwe = 1'b1;
                q.push_back(c);
            end
            if (is_st) begin
                m_ret++;
                len = q.size() - n0;
                return;
            end
        end
        c = idle_cyc(3'd4);
        c.rfwe = 1'b1; c.pcwe = 1'b1;
        c.wbsel = is_ld ? 2'd1 : (is_jmp ? 2'd2 : 2'd0);
        c.pcsel = is_jmp ? 2'd2 : 2'd0;
        q.push_back(c);
        m_ret++;
        len = q.size() - n0;
    endtask

    task automatic gen_halt(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = idle_cyc(3'd5); c.ia = 1'b1; c.da = 1'b1; q.push_back(c);
        end
    endtask

    task automatic run_q();
        cyc_t c;
        logic [77:0] a, e;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk); #1;
            bus_if.imem_ack   = c.ia;
            bus_if.imem_rdata = c.rd;
            bus_if.dmem_ack   = c.da;
            branch_taken      = c.bt;
            @(negedge clk);
            e = {c.st, c.ireq, c.dreq, c.dwe, c.pcwe, c.pcsel, c.rfwe, c.wbsel,
                 c.hlt, c.ill, c.ret, c.ir};
            a = {state, bus_if.imem_req, bus_if.dmem_req, bus_if.dmem_we, pc_we, pc_sel,
                 rf_we, wb_sel, halt, illegal, retired, ir};
            check("cycle", 128'(a), 128'(e));
        end
    endtask

    // Quiet one cycle (acks low) and pin the retired count with a literal.
    task automatic pin_retired(input string nm, input logic [31:0] exp);
        @(posedge clk); #1;
        bus_if.imem_ack = 1'b0;
        bus_if.dmem_ack = 1'b0;
        @(negedge clk);
        check(nm, 128'({state, retired}), 128'({3'd0, exp}));
    endtask

    task automatic do_reset(input int edges);
        rstn = 1'b0;
        bus_if.imem_ack = 1'b0;
        bus_if.dmem_ack = 1'b0;
        branch_taken = 1'b0;
        repeat (edges) @(posedge clk);
        @(negedge clk);
        check("reset_state", 128'({state, ir, retired, illegal, halt, bus_if.imem_req,
                                   bus_if.dmem_req, pc_we, rf_we}),
              128'({3'd0, RESET_IR, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        rstn = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        logic [6:0]  ops [7];
        logic [31:0] instr;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
        bus_if.imem_rdata = 32'd0;
        do_reset(2);

        gen_instr(32'h002081B3, 0, 0, 1'b0, len);
        check("add_latency", 128'(len), 128'(4));
        run_q();
        pin_retired("add_retired", 32'd1);

        gen_instr(32'h0000A183, 0, 3, 1'b0, len);
        check("lw_latency", 128'(len), 128'(8));
        run_q();

        gen_instr(32'h00208463, 0, 0, 1'b1, len);
        check("beq_t_latency", 128'(len), 128'(3));
        gen_instr(32'h00208463, 0, 0, 1'b0, len);
        check("beq_n_latency", 128'(len), 128'(3));
        run_q();

        gen_instr(32'h0020A023, 0, 0, 1'b0, len);
        check("sw_latency", 128'(len), 128'(4));
        gen_instr(32'h008000EF, 0, 0, 1'b0, len);
        check("jal_latency", 128'(len), 128'(4));
        run_q();
        pin_retired("retired_after_directed", 32'd6);

        for (int k = 0; k < 150; k++) begin
            instr = $urandom;
            instr[6:0] = ops[$urandom_range(0, 6)];
            gen_instr(instr, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), len);
        end
        run_q();

        gen_instr(32'h00000073, 1, 0, 1'b0, len);
        gen_halt(4);
        run_q();
        check("sys_halt", 128'({halt, illegal}), 128'({1'b1, 1'b0}));

        do_reset(1);
        gen_instr(32'h0000007F, 2, 0, 1'b0, len);
        gen_halt(5);
        run_q();
        check("illegal_halt", 128'({halt, illegal, state}), 128'({1'b1, 1'b1, 3'd5}));

        @(posedge clk); #1;
        do_reset(1);
        check("illegal_cleared", 128'({illegal, halt}), 128'({1'b0, 1'b0}));

        // Reset landing in the middle of an instruction-fetch wait.
        @(posedge clk); #1;
        bus_if.imem_ack = 1'b0;
        @(negedge clk);
        check("if_wait_req", 128'(bus_if.imem_req), 128'(1'b1));
        @(posedge clk); #1;
        rstn = 1'b0;
        @(negedge clk);
        check("if_wait_rst_req", 128'({bus_if.imem_req, pc_we, rf_we}), 128'(3'b000));
        do_reset(1);
        gen_instr(32'h00500093, 1, 0, 1'b0, len);
        run_q();
        pin_retired("post_reset_retired", 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
